// File: rtl/avm_rr_arbiter.sv
// avm_rr_arbiter: two-requester round-robin arbiter in front of one Avalon-MM slave.
// The grant is locked for a whole transfer. Command and write data are muxed downstream.
// Read data and waitrequest are routed back only to the owner.
// Optional watchdog: define AVM_RR_ARBITER_TIMEOUT_EN to abort stalled transfers
// after TIMEOUT_CYCLES stalled cycles.
module avm_rr_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                r0_cs_i,
    input  logic [ADDR_W-1:0]   r0_address_i,
    input  logic                r0_read_i,
    input  logic                r0_write_i,
    input  logic [DATA_W-1:0]   r0_writedata_i,
    input  logic [DATA_W/8-1:0] r0_byteenable_i,
    output logic                r0_waitrequest_o,
    output logic [DATA_W-1:0]   r0_readdata_o,
    output logic                r0_err_o,
    input  logic                r1_cs_i,
    input  logic [ADDR_W-1:0]   r1_address_i,
    input  logic                r1_read_i,
    input  logic                r1_write_i,
    input  logic [DATA_W-1:0]   r1_writedata_i,
    input  logic [DATA_W/8-1:0] r1_byteenable_i,
    output logic                r1_waitrequest_o,
    output logic [DATA_W-1:0]   r1_readdata_o,
    output logic                r1_err_o,
    output logic                avm_cs_o,
    output logic [ADDR_W-1:0]   avm_address_o,
    output logic                avm_read_o,
    output logic                avm_write_o,
    output logic [DATA_W-1:0]   avm_writedata_o,
    output logic [DATA_W/8-1:0] avm_byteenable_o,
    input  logic                avm_waitrequest_i,
    input  logic [DATA_W-1:0]   avm_readdata_i,
    output logic [1:0]          grant_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t r_state, w_next;
    logic   r_last_owner, w_next_last;
    logic   w_req0, w_req1, w_own0, w_own1, w_own_req, w_done, w_timeout, w_drive;

    assign w_req0    = r0_cs_i & (r0_read_i | r0_write_i);
    assign w_req1    = r1_cs_i & (r1_read_i | r1_write_i);
    assign w_own0    = (r_state == OWN0);
    assign w_own1    = (r_state == OWN1);
    assign w_own_req = w_own1 ? w_req1 : w_req0;
    assign w_done    = w_own_req & ~avm_waitrequest_i;

`ifdef AVM_RR_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Stall counter: cleared while idle (every grant starts from IDLE), counts stalled owned cycles
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            r_cnt <= '0;
        else if (r_state == IDLE)
            r_cnt <= '0;
        else if (avm_waitrequest_i)
            r_cnt <= r_cnt + 1'b1;
    end

    assign w_timeout = (w_own0 | w_own1) && (r_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    // State and fairness pointer registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= IDLE;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_next;
            r_last_owner <= w_next_last;
        end
    end

    // Next state: arbitrate only in IDLE; a dropped request leaves without moving the pointer
    always_comb begin
        w_next      = r_state;
        w_next_last = r_last_owner;
        case (r_state)
            IDLE: begin
                if (w_req0 & w_req1)
                    w_next = r_last_owner ? OWN0 : OWN1;
                else if (w_req0)
                    w_next = OWN0;
                else if (w_req1)
                    w_next = OWN1;
            end
            OWN0, OWN1: begin
                if (!w_own_req) begin
                    w_next = IDLE;
                end else if (w_done | w_timeout) begin
                    w_next      = IDLE;
                    w_next_last = w_own1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Downstream command mux; forced quiet when idle or on a watchdog abort
    assign w_drive          = (w_own0 | w_own1) & ~w_timeout;
    assign avm_cs_o         = w_drive & (w_own1 ? r1_cs_i : r0_cs_i);
    assign avm_read_o       = w_drive & (w_own1 ? r1_read_i : r0_read_i);
    assign avm_write_o      = w_drive & (w_own1 ? r1_write_i : r0_write_i);
    assign avm_address_o    = w_drive ? (w_own1 ? r1_address_i : r0_address_i) : '0;
    assign avm_writedata_o  = w_drive ? (w_own1 ? r1_writedata_i : r0_writedata_i) : '0;
    assign avm_byteenable_o = w_drive ? (w_own1 ? r1_byteenable_i : r0_byteenable_i) : '0;

    // Response routing: the non-owner is always stalled and sees zero data
    assign r0_waitrequest_o = w_own0 ? (avm_waitrequest_i & ~w_timeout) : 1'b1;
    assign r1_waitrequest_o = w_own1 ? (avm_waitrequest_i & ~w_timeout) : 1'b1;
    assign r0_readdata_o    = (w_own0 & ~w_timeout) ? avm_readdata_i : '0;
    assign r1_readdata_o    = (w_own1 & ~w_timeout) ? avm_readdata_i : '0;
    assign r0_err_o         = w_own0 & w_timeout;
    assign r1_err_o         = w_own1 & w_timeout;
    assign grant_o          = {w_own1, w_own0};

endmodule

// File: tb/tb_avm_rr_arbiter.sv
// tb_avm_rr_arbiter: table-driven directed check of avm_rr_arbiter plus reset/watchdog sequences.
// Built with TIMEOUT_CYCLES=8; the watchdog section adapts to AVM_RR_ARBITER_TIMEOUT_EN.
module tb_avm_rr_arbiter;

    typedef struct packed {
        logic        cs;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } cmd_t;

    // Observable outputs: grant, downstream command, {r1,r0} waitrequest, readdata, {r1,r0} err
    typedef struct packed {
        logic [1:0]  g;
        cmd_t        avm;
        logic [1:0]  w;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  e;
    } obs_t;

    typedef struct packed {
        cmd_t        c0;
        cmd_t        c1;
        logic        wt;
        logic [31:0] rdi;
        obs_t        x;
    } vec_t;

    localparam cmd_t NC  = '0;
    localparam obs_t IDL = '{2'b00, '0, 2'b11, 32'h0, 32'h0, 2'b00};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    cmd_t        c0 = '0, c1 = '0;
    logic        wt = 1'b0;
    logic [31:0] rdi = '0;
    logic        r0_wait, r1_wait, r0_err, r1_err;
    logic [31:0] r0_rd, r1_rd;
    logic        avm_cs, avm_rd, avm_wr;
    logic [31:0] avm_a, avm_d;
    logic [3:0]  avm_be;
    logic [1:0]  grant;

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vq[$];

    avm_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .r0_cs_i          (c0.cs),
        .r0_address_i     (c0.a),
        .r0_read_i        (c0.rd),
        .r0_write_i       (c0.wr),
        .r0_writedata_i   (c0.d),
        .r0_byteenable_i  (c0.be),
        .r0_waitrequest_o (r0_wait),
        .r0_readdata_o    (r0_rd),
        .r0_err_o         (r0_err),
        .r1_cs_i          (c1.cs),
        .r1_address_i     (c1.a),
        .r1_read_i        (c1.rd),
        .r1_write_i       (c1.wr),
        .r1_writedata_i   (c1.d),
        .r1_byteenable_i  (c1.be),
        .r1_waitrequest_o (r1_wait),
        .r1_readdata_o    (r1_rd),
        .r1_err_o         (r1_err),
        .avm_cs_o         (avm_cs),
        .avm_address_o    (avm_a),
        .avm_read_o       (avm_rd),
        .avm_write_o      (avm_wr),
        .avm_writedata_o  (avm_d),
        .avm_byteenable_o (avm_be),
        .avm_waitrequest_i(wt),
        .avm_readdata_i   (rdi),
        .grant_o          (grant)
    );

    always #5 clk = ~clk;

    function automatic cmd_t cmd(logic cs, logic rd, logic wr, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        return '{cs, rd, wr, a, d, be};
    endfunction

    function automatic obs_t ob(logic [1:0] g, cmd_t a, logic [1:0] w, logic [31:0] d0, logic [31:0] d1, logic [1:0] e);
        return '{g, a, w, d0, d1, e};
    endfunction

    task automatic add(input cmd_t a0, input cmd_t a1, input logic w, input logic [31:0] r, input obs_t x);
        vq.push_back('{a0, a1, w, r, x});
    endtask

    task automatic check(input obs_t x, input string nm);
        obs_t got;
        got = '{grant, '{avm_cs, avm_rd, avm_wr, avm_a, avm_d, avm_be},
                {r1_wait, r0_wait}, r0_rd, r1_rd, {r1_err, r0_err}};
        n_chk++;
        if (got !== x) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, x);
        end
    endtask

    // Drive one cycle of inputs, check before the edge, then advance past the edge
    task automatic apply(input vec_t v, input string nm);
        c0  = v.c0;
        c1  = v.c1;
        wt  = v.wt;
        rdi = v.rdi;
        #1;
        check(v.x, nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmd_t W0, W1, R0, R1, R0S, B1, V0, V0D, V1, RR0, RR1, TO, T1;
        logic [31:0] r;

        W0  = cmd(1, 0, 1, 32'h10, 32'h1111_1111, 4'hF);
        W1  = cmd(1, 0, 1, 32'h20, 32'h2222_2222, 4'hF);
        R0  = cmd(1, 1, 0, 32'h3000, 32'h0, 4'hF);
        R1  = cmd(1, 1, 0, 32'h4000, 32'h0, 4'hF);
        R0S = cmd(1, 1, 0, 32'h0000_0100, 32'h0, 4'hF);
        B1  = cmd(1, 0, 1, 32'h30, 32'h00AB_0000, 4'b0100);
        V0  = cmd(1, 1, 0, 32'h50, 32'h0, 4'hF);
        V0D = cmd(0, 1, 0, 32'h50, 32'h0, 4'hF);
        V1  = cmd(1, 1, 0, 32'h60, 32'h0, 4'hF);
        RR0 = cmd(1, 0, 1, 32'h90, 32'h0BAD_F00D, 4'hF);
        RR1 = cmd(1, 1, 0, 32'h70, 32'h0, 4'hF);
        TO  = cmd(1, 1, 0, 32'h80, 32'h0, 4'hF);
        T1  = cmd(1, 0, 1, 32'hA0, 32'h5555_AAAA, 4'h3);

        // Simultaneous writes right after reset: r0 first, one idle cycle, then r1
        add(W0, W1, 0, 0, IDL);
        add(W0, W1, 0, 0, ob(2'b01, W0, 2'b10, 0, 0, 0));
        add(NC, W1, 0, 0, IDL);
        add(NC, W1, 0, 0, ob(2'b10, W1, 2'b01, 0, 0, 0));
        add(NC, NC, 0, 0, IDL);
        // Continuous contention, 4 reads each: strict alternation starting with r0
        for (int k = 0; k < 8; k++) begin
            r = 32'hD000_0000 + k;
            add(R0, R1, 0, r, IDL);
            if (k % 2 == 0)
                add(R0, R1, 0, r, ob(2'b01, R0, 2'b10, r, 0, 0));
            else
                add(R0, R1, 0, r, ob(2'b10, R1, 2'b01, 0, r, 0));
        end
        add(NC, NC, 0, 0, IDL);
        // Single r0 read with 3 stall cycles; only r0 sees slave data
        add(R0S, NC, 1, 32'h1234_5678, IDL);
        for (int k = 0; k < 3; k++)
            add(R0S, NC, 1, 32'h1234_5678, ob(2'b01, R0S, 2'b11, 32'h1234_5678, 0, 0));
        add(R0S, NC, 0, 32'hCAFE_F00D, ob(2'b01, R0S, 2'b10, 32'hCAFE_F00D, 0, 0));
        add(NC, NC, 1, 32'h1234_5678, IDL);
        // r1 byte write: lane mask visible only while r1 owns the port
        add(NC, B1, 1, 0, IDL);
        add(NC, B1, 1, 0, ob(2'b10, B1, 2'b11, 0, 0, 0));
        add(NC, B1, 0, 0, ob(2'b10, B1, 2'b01, 0, 0, 0));
        add(NC, NC, 1, 0, IDL);
        // r0 drops cs mid-transfer: pointer must stay at r1, so the next tie still goes to r0
        add(V0, NC, 1, 0, IDL);
        add(V0, NC, 1, 0, ob(2'b01, V0, 2'b11, 0, 0, 0));
        add(V0D, NC, 1, 0, ob(2'b01, V0D, 2'b11, 0, 0, 0));
        add(V0, V1, 0, 0, IDL);
        add(V0, V1, 0, 0, ob(2'b01, V0, 2'b10, 0, 0, 0));
        add(NC, V1, 0, 0, IDL);
        add(NC, V1, 0, 0, ob(2'b10, V1, 2'b01, 0, 0, 0));
        add(NC, NC, 0, 0, IDL);

        // Reset state
        #1;
        check(IDL, "reset_state");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vq[i])
            apply(vq[i], $sformatf("vec%0d", i));

        // Asynchronous reset during an OWN1 stall
        apply('{NC, RR1, 1'b1, 32'h0, IDL}, "rst_arb");
        #1;
        check(ob(2'b10, RR1, 2'b11, 0, 0, 0), "rst_own1");
        rst_n = 1'b0;
        #1;
        check(IDL, "rst_async");
        @(posedge clk);
        #1;
        check(IDL, "rst_held");
        rst_n = 1'b1;
        apply('{RR0, RR1, 1'b0, 32'h0, IDL}, "rst_tie_arb");
        apply('{RR0, RR1, 1'b0, 32'h0, ob(2'b01, RR0, 2'b10, 0, 0, 0)}, "rst_tie_r0");
        apply('{NC, RR1, 1'b0, 32'h0, IDL}, "rst_gap");
        apply('{NC, RR1, 1'b0, 32'h0, ob(2'b10, RR1, 2'b01, 0, 0, 0)}, "rst_then_r1");
        apply('{NC, NC, 1'b0, 32'h0, IDL}, "rst_idle");

        // Slave stalls forever on an r0 read
        apply('{TO, NC, 1'b1, 32'h5A5A_5A5A, IDL}, "to_arb");
`ifdef AVM_RR_ARBITER_TIMEOUT_EN
        for (int k = 0; k < 8; k++)
            apply('{TO, NC, 1'b1, 32'h5A5A_5A5A, ob(2'b01, TO, 2'b11, 32'h5A5A_5A5A, 0, 0)},
                  $sformatf("to_stall%0d", k));
        apply('{TO, NC, 1'b1, 32'h5A5A_5A5A, ob(2'b01, NC, 2'b10, 0, 0, 2'b01)}, "to_abort");
        apply('{NC, NC, 1'b1, 32'h0, IDL}, "to_idle");
        apply('{TO, T1, 1'b0, 32'h0, IDL}, "to_tie_arb");
        apply('{TO, T1, 1'b0, 32'h0, ob(2'b10, T1, 2'b01, 0, 0, 0)}, "to_tie_r1");
        apply('{TO, NC, 1'b0, 32'h0, IDL}, "to_gap");
        apply('{TO, NC, 1'b0, 32'h0, ob(2'b01, TO, 2'b10, 0, 0, 0)}, "to_r0_done");
        apply('{NC, NC, 1'b0, 32'h0, IDL}, "to_end");
`else
        for (int k = 0; k < 12; k++)
            apply('{TO, NC, 1'b1, 32'h5A5A_5A5A, ob(2'b01, TO, 2'b11, 32'h5A5A_5A5A, 0, 0)},
                  $sformatf("hold%0d", k));
        apply('{TO, NC, 1'b0, 32'h5A5A_5A5A, ob(2'b01, TO, 2'b10, 32'h5A5A_5A5A, 0, 0)}, "hold_done");
        apply('{NC, NC, 1'b0, 32'h0, IDL}, "hold_end");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
